// File: rtl/axi_wr_resp_gen.sv
// ============================================================================
// Module   : axi_wr_resp_gen
// Summary  : AXI4 write-path sink. Queues AW, counts W beats per burst, checks
//            w_last alignment and address decode, returns one B per burst.
// Options  : AXI_WR_USER_ECHO_EN - echo the burst's aw_user on b_user.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wr_resp_gen #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        AXI_USER_WIDTH = 1,
  parameter int                        AW_DEPTH       = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] SIZE_BYTES     = 32'h0001_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
  input  logic [7:0]                aw_len,
  input  logic [AXI_USER_WIDTH-1:0] aw_user,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic                      w_last,
  input  logic                      w_valid,
  output logic                      w_ready,
  output logic [AXI_ID_WIDTH-1:0]   b_id,
  output logic [1:0]                b_resp,
  output logic [AXI_USER_WIDTH-1:0] b_user,
  output logic                      b_valid,
  input  logic                      b_ready,
  output logic [15:0]               wr_err_cnt
);

  localparam int                      c_ptr_w   = $clog2(AW_DEPTH);
  localparam logic [c_ptr_w:0]        c_depth   = AW_DEPTH[c_ptr_w:0];
  localparam logic [AXI_ADDR_WIDTH:0] c_win_lo  = {1'b0, BASE_ADDR};
  localparam logic [AXI_ADDR_WIDTH:0] c_win_hi  = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // ---------------------------------------------------------------- AW queue
  logic [AXI_ID_WIDTH-1:0] r_fifo_id  [AW_DEPTH];
  logic [7:0]              r_fifo_len [AW_DEPTH];
  logic                    r_fifo_dec [AW_DEPTH];
  logic [c_ptr_w-1:0]      r_wr_ptr;
  logic [c_ptr_w-1:0]      r_rd_ptr;
  logic [c_ptr_w:0]        r_count;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_aw_dec;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  assign w_empty  = (r_count == '0);
  assign aw_ready = (r_count != c_depth);
  assign w_push   = aw_valid && aw_ready;
  assign w_pop    = (r_state == S_IDLE) && !w_empty;

  // Decode is resolved at push so only one flag per entry is kept, not the address.
  assign w_aw_dec = ({1'b0, aw_addr} < c_win_lo) || ({1'b0, aw_addr} >= c_win_hi);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]  <= aw_id;
      r_fifo_len[r_wr_ptr] <= aw_len;
      r_fifo_dec[r_wr_ptr] <= w_aw_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef AXI_WR_USER_ECHO_EN
  logic [AXI_USER_WIDTH-1:0] r_fifo_user [AW_DEPTH];
  logic [AXI_USER_WIDTH-1:0] r_user;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_user[r_wr_ptr] <= aw_user;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_user <= '0;
    else if (w_pop) r_user <= r_fifo_user[r_rd_ptr];
  end

  assign b_user = r_user;
`else
  logic w_unused_user;
  assign w_unused_user = ^aw_user;
  assign b_user        = '0;
`endif

  // ---------------------------------------------------------------- engine
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [7:0]              r_len;
  logic                    r_dec;
  logic [7:0]              r_beat_cnt;
  logic                    r_err;
  logic [1:0]              r_resp;

  logic w_beat_hs;
  logic w_last_beat;
  logic w_mismatch;
  logic w_b_hs;

  assign w_beat_hs   = w_valid && w_ready;
  assign w_last_beat = (r_beat_cnt == r_len);
  assign w_mismatch  = (w_last != w_last_beat);
  assign w_b_hs      = b_valid && b_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty)                  w_state_nxt = S_DATA;
      S_DATA:  if (w_beat_hs && w_last_beat)  w_state_nxt = S_RESP;
      S_RESP:  if (b_ready)                   w_state_nxt = S_IDLE;
      default:                                w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    b_valid = 1'b0;
    case (r_state)
      S_DATA:  w_ready = 1'b1;
      S_RESP:  b_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id       <= '0;
      r_len      <= '0;
      r_dec      <= 1'b0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
      r_resp     <= c_resp_okay;
    end else if (w_pop) begin
      r_id       <= r_fifo_id[r_rd_ptr];
      r_len      <= r_fifo_len[r_rd_ptr];
      r_dec      <= r_fifo_dec[r_rd_ptr];
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_beat_hs) begin
      if (w_mismatch) r_err <= 1'b1;
      // Response is latched on the final beat so b_resp holds steady through RESP.
      if (w_last_beat) begin
        if (r_dec)                    r_resp <= c_resp_decerr;
        else if (r_err || w_mismatch) r_resp <= c_resp_slverr;
        else                          r_resp <= c_resp_okay;
      end else begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
    end
  end

  assign b_id   = r_id;
  assign b_resp = r_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_err_cnt <= '0;
    else if (w_b_hs && (r_resp != c_resp_okay) && (wr_err_cnt != 16'hFFFF))
      wr_err_cnt <= wr_err_cnt + 16'd1;
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_resp_gen.sv
// ============================================================================
// Module   : tb_axi_wr_resp_gen
// Summary  : Self-checking bench for axi_wr_resp_gen: directed scenarios plus a
//            randomized phase checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_wr_resp_gen;

  localparam longint c_base = 64'h0;
  localparam longint c_size = 64'h1_0000;
  localparam int     c_nrand = 40;

`ifdef AXI_WR_USER_ECHO_EN
  localparam bit c_echo = 1'b1;
`else
  localparam bit c_echo = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [0:0]  aw_user;
  logic        aw_valid;
  logic        aw_ready;
  logic        w_last;
  logic        w_valid;
  logic        w_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic [0:0]  b_user;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] wr_err_cnt;

  always #5 clk = ~clk;

  axi_wr_resp_gen dut (
    .clk        (clk),
    .rst        (rst),
    .aw_id      (aw_id),
    .aw_addr    (aw_addr),
    .aw_len     (aw_len),
    .aw_user    (aw_user),
    .aw_valid   (aw_valid),
    .aw_ready   (aw_ready),
    .w_last     (w_last),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .b_id       (b_id),
    .b_resp     (b_resp),
    .b_user     (b_user),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .wr_err_cnt (wr_err_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    int          len;
    logic        user;
  } aw_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } b_t;

  aw_t aw_q[$];
  b_t  exp_q[$];
  int  nb   = 0;
  bit  stop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [31:0] addr, input bit bad_last);
    longint a;
    a = longint'({32'b0, addr});
    if (a < c_base || a >= c_base + c_size) return 2'b11;
    return bad_last ? 2'b10 : 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr,
                       input int len, input logic user);
    bit hs;
    hs = 1'b0;
    aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_user = user; aw_valid = 1'b1;
    for (int k = 0; k < 200 && !hs; k++) begin
      @(negedge clk);
      hs = aw_ready;
      tick();
    end
    aw_valid = 1'b0;
    if (!hs) chk("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_w(input int nbeats, input int last_pos);
    bit hs;
    for (int i = 0; i < nbeats; i++) begin
      hs = 1'b0;
      w_valid = 1'b1;
      w_last  = (i == last_pos);
      for (int k = 0; k < 200 && !hs; k++) begin
        @(negedge clk);
        hs = w_ready;
        tick();
      end
      if (!hs) chk("w_timeout", 32'd0, 32'd1);
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
  endtask

  task automatic do_b(input logic [3:0] id, input logic [1:0] resp,
                      input logic user, input int hold);
    bit seen;
    logic [3:0] s_id;
    logic [1:0] s_resp;
    seen = 1'b0;
    b_ready = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = b_valid;
    end
    if (!seen) chk("b_timeout", 32'd0, 32'd1);
    s_id = b_id; s_resp = b_resp;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("b_hold_valid", 32'(b_valid), 32'd1);
      chk("b_hold_id", 32'(b_id), 32'(s_id));
      chk("b_hold_resp", 32'(b_resp), 32'(s_resp));
    end
    @(posedge clk); #1;
    b_ready = 1'b1;
    @(negedge clk);
    chk("b_valid", 32'(b_valid), 32'd1);
    chk("b_id", 32'(b_id), 32'(id));
    chk("b_resp", 32'(b_resp), 32'(resp));
    chk("b_user", 32'(b_user), 32'(user & c_echo));
    chk("err_cnt_pre", 32'(wr_err_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
    b_ready = 1'b0;
    if (resp != 2'b00 && exp_cnt < 16'hFFFF) exp_cnt++;
    @(negedge clk);
    chk("err_cnt_post", 32'(wr_err_cnt), 32'(exp_cnt));
    chk("b2w_early", 32'(w_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_user = '0; aw_valid = 1'b0;
    w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_b_id", 32'(b_id), 32'd0);
    chk("rst_b_resp", 32'(b_resp), 32'd0);
    chk("rst_b_user", 32'(b_user), 32'd0);
    chk("rst_err_cnt", 32'(wr_err_cnt), 32'd0);
    chk("rst_aw_ready", 32'(aw_ready), 32'd1);
    tick();

    // single burst in window with latency checks
    do_aw(4'd3, 32'h100, 3, 1'b0);
    @(negedge clk);
    chk("aw2w_early", 32'(w_ready), 32'd0);
    @(negedge clk);
    chk("aw2w_lat", 32'(w_ready), 32'd1);
    tick();
    do_w(4, 3);
    @(negedge clk);
    chk("w2b_lat", 32'(b_valid), 32'd1);
    chk("w_ready_in_resp", 32'(w_ready), 32'd0);
    tick();
    do_b(4'd3, 2'b00, 1'b0, 0);

    // early last, decode errors, window edges, len=0 without last, user echo
    do_aw(4'd1, 32'h200, 3, 1'b0);      do_w(4, 1); do_b(4'd1, 2'b10, 1'b0, 0);
    do_aw(4'd2, 32'h1_0000, 0, 1'b0);   do_w(1, 0); do_b(4'd2, 2'b11, 1'b0, 0);
    do_aw(4'd9, 32'h0_FFFF, 0, 1'b0);   do_w(1, 0); do_b(4'd9, 2'b00, 1'b0, 0);
    do_aw(4'd10, 32'hFFFF_FFFF, 1, 1'b0); do_w(2, 0); do_b(4'd10, 2'b11, 1'b0, 0);
    do_aw(4'd11, 32'h10, 0, 1'b0);      do_w(1, -1); do_b(4'd11, 2'b10, 1'b0, 0);
    do_aw(4'd4, 32'h300, 0, 1'b1);      do_w(1, 0); do_b(4'd4, 2'b00, 1'b1, 0);

    // queue full, backpressure, in-order responses
    for (int i = 0; i < 5; i++)
      do_aw(4'(5 + i), (i == 2) ? 32'h2_0000 : 32'(32'h400 + i * 16), 1, 1'b0);
    @(negedge clk);
    chk("aw_full", 32'(aw_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      do_w(2, 1);
      do_b(4'(5 + i), (i == 2) ? 2'b11 : 2'b00, 1'b0, (i == 0) ? 10 : 0);
      if (i == 0) begin
        @(negedge clk);
        chk("b2w_lat", 32'(w_ready), 32'd1);
        chk("aw_free", 32'(aw_ready), 32'd1);
        tick();
      end
    end

    // reset mid-burst
    do_aw(4'd6, 32'h40, 3, 1'b0);
    do_w(2, 3);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("mid_rst_w_ready", 32'(w_ready), 32'd0);
    chk("mid_rst_b_valid", 32'(b_valid), 32'd0);
    chk("mid_rst_aw_ready", 32'(aw_ready), 32'd1);
    chk("mid_rst_err_cnt", 32'(wr_err_cnt), 32'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_b", 32'(b_valid), 32'd0);
    tick();
    do_aw(4'd7, 32'h80, 0, 1'b0); do_w(1, 0); do_b(4'd7, 2'b00, 1'b0, 0);

    // randomized traffic against the transaction model
    fork
      begin : aw_proc
        for (int i = 0; i < c_nrand && !stop; i++) begin
          aw_t a;
          bit hs;
          int sel;
          sel = int'($urandom_range(0, 4));
          a.id   = 4'($urandom);
          a.len  = int'($urandom_range(0, 7));
          a.user = 1'($urandom);
          if (sel == 0)      a.addr = 32'h1_0000 + ($urandom % 256);
          else if (sel == 1) a.addr = $urandom;
          else               a.addr = $urandom % 32'h1_0000;
          repeat ($urandom_range(0, 2)) tick();
          aw_id = a.id; aw_addr = a.addr; aw_len = 8'(a.len); aw_user = a.user;
          aw_valid = 1'b1;
          hs = 1'b0;
          while (!hs && !stop) begin
            @(negedge clk);
            hs = aw_ready;
            if (hs) aw_q.push_back(a);
            tick();
          end
          aw_valid = 1'b0;
        end
      end
      begin : w_proc
        for (int n = 0; n < c_nrand && !stop; n++) begin
          aw_t a;
          b_t  e;
          int  flip;
          while (aw_q.size() == 0 && !stop) tick();
          if (!stop) begin
            a = aw_q.pop_front();
            flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, a.len)) : -1;
            for (int i = 0; i <= a.len && !stop; i++) begin
              bit hs;
              repeat ($urandom_range(0, 1)) tick();
              w_valid = 1'b1;
              w_last  = (i == a.len) ^ (i == flip);
              hs = 1'b0;
              while (!hs && !stop) begin
                @(negedge clk);
                hs = w_ready;
                tick();
              end
              w_valid = 1'b0;
              w_last  = 1'b0;
            end
            e.id   = a.id;
            e.resp = model_resp(a.addr, flip >= 0);
            e.user = a.user & c_echo;
            exp_q.push_back(e);
          end
        end
      end
      begin : b_proc
        bit         pending;
        logic [3:0] s_id;
        logic [1:0] s_resp;
        pending = 1'b0;
        while (nb < c_nrand && !stop) begin
          b_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (pending) begin
            chk("rnd_b_held", 32'(b_valid), 32'd1);
            chk("rnd_b_id_stable", 32'(b_id), 32'(s_id));
            chk("rnd_b_resp_stable", 32'(b_resp), 32'(s_resp));
          end
          pending = 1'b0;
          if (b_valid && b_ready) begin
            if (exp_q.size() == 0) begin
              chk("rnd_b_unexpected", 32'd1, 32'd0);
            end else begin
              b_t e;
              e = exp_q.pop_front();
              chk("rnd_b_id", 32'(b_id), 32'(e.id));
              chk("rnd_b_resp", 32'(b_resp), 32'(e.resp));
              chk("rnd_b_user", 32'(b_user), 32'(e.user));
              chk("rnd_err_cnt", 32'(wr_err_cnt), 32'(exp_cnt));
              if (e.resp != 2'b00 && exp_cnt < 16'hFFFF) exp_cnt++;
            end
            nb++;
          end else if (b_valid) begin
            pending = 1'b1;
            s_id    = b_id;
            s_resp  = b_resp;
          end
          @(posedge clk); #1;
        end
        b_ready = 1'b0;
      end
      begin : watchdog
        for (int c = 0; c < 30000 && nb < c_nrand; c++) tick();
        stop = 1'b1;
      end
    join
    chk("rnd_all_b", 32'(nb), 32'(c_nrand));
    chk("rnd_exp_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("rnd_err_cnt_final", 32'(wr_err_cnt), 32'(exp_cnt));
    chk("rnd_idle_b_valid", 32'(b_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
